uart_sample_deserializer: RTL

- Sits between the UART receiver and the FIR control/datapath.
- Assembles consecutive received bytes, least-significant byte first, into one SAMPLE_WIDTH-bit sample.
- Presents each sample on a one-deep valid/ready output register.
- Flags dropped samples and, optionally, stale partial samples, so the FIR sees only whole, aligned samples.

---
 rtl/uart_sample_deserializer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_sample_deserializer.sv
// Packs LSB-first UART bytes into SAMPLE_WIDTH-bit samples behind a one-deep valid/ready register.
// Optional inter-byte timeout for partial samples is built only when DESER_TIMEOUT_EN is defined.
module uart_sample_deserializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_en,
  input  logic [7:0]                        i_rx_data,
  input  logic                              i_rx_end,
  input  logic                              i_ready,
  output logic [SAMPLE_WIDTH-1:0]           o_sample,
  output logic                              o_des_valid,
  output logic [$clog2(SAMPLE_WIDTH/8):0]   o_byte_idx,
  output logic                              o_overrun,
  output logic                              o_timeout
);

  // state   | meaning
  // IDLE    | no bytes held toward the next sample
  // COLLECT | 1..BYTES-1 bytes held in the assembly register

  localparam int BYTES = SAMPLE_WIDTH / 8;
  localparam int IDX_W = $clog2(BYTES) + 1;

  if ((SAMPLE_WIDTH % 8) != 0 || SAMPLE_WIDTH < 8 || SAMPLE_WIDTH > 64 || TIMEOUT < 2)
  begin : g_param_check
    $error("uart_sample_deserializer: SAMPLE_WIDTH must be 8..64 in steps of 8, TIMEOUT >= 2");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] asm_q, asm_d;
  logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
  logic                    valid_q, valid_d;
  logic                    overrun_q, overrun_d;
  logic                    capture;
  logic                    complete;

`ifdef DESER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT);
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             timeout_q, timeout_d;
`endif

  assign capture = i_en & i_rx_end;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    sample_d  = sample_q;
    valid_d   = valid_q & ~i_ready;
    overrun_d = overrun_q;
    complete  = 1'b0;
`ifdef DESER_TIMEOUT_EN
    tmr_d     = tmr_q;
    timeout_d = 1'b0;
`endif

    if (capture) begin
      for (int k = 0; k < BYTES; k++) begin
        if (cnt_q == IDX_W'(k)) asm_d[8*k +: 8] = i_rx_data;
      end
      if (cnt_q == IDX_W'(BYTES - 1)) begin
        complete = 1'b1;
        cnt_d    = '0;
        state_d  = IDLE;
      end else begin
        cnt_d    = cnt_q + 1'b1;
        state_d  = COLLECT;
      end
`ifdef DESER_TIMEOUT_EN
      tmr_d = '0;
    end else if (i_en && state_q == COLLECT) begin
      // a byte landing in the expiry cycle takes the capture branch above instead
      if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
        tmr_d     = '0;
        cnt_d     = '0;
        state_d   = IDLE;
        timeout_d = 1'b1;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
`endif
    end

    // the completing byte is taken from asm_d so the sample loads in the same edge
    if (complete) begin
      if (!valid_q || i_ready) begin
        sample_d = asm_d;
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      asm_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef DESER_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_sample    = sample_q;
  assign o_des_valid = valid_q;
  assign o_byte_idx  = cnt_q;
  assign o_overrun   = overrun_q;

endmodule
